counter_mod: RTL and testbench
==============================

Name: counter_mod

Overview:
- Parametrised up/down modulo counter with programmable step, programmable terminal value (top), wrap/saturate mode, compare-hit pulse and sticky step-error flag.
- Successor to the fixed ±1 binary counter. Used in the angle/tooth-count path, where tooth counts wrap at a non-power-of-two modulus and the step is not always 1.
- Single clock domain; all outputs are registered except cmp_eq.

Parameters:
- WIDTH, 8, width of count value, top, cmp and d_load.
- STEP_WIDTH, 4, width of step input. Must be ≤ WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- srst  input  1  reset: synchronous, active-low (0 = reset on next rising clk edge).
- ena  input  1  count enable.
- sel  input  1  direction: 0 = up, 1 = down.
- mode  input  1  0 = wrap at boundary, 1 = saturate at boundary.
- sload  input  1  synchronous load strobe.
- d_load  input  WIDTH  load value.
- step  input  STEP_WIDTH  increment/decrement magnitude.
- top  input  WIDTH  terminal value; legal range is 0..top inclusive (modulus top+1).
- cmp  input  WIDTH  compare value.
- err_clr  input  1  clears err.
- q  output  WIDTH  count value.
- carry_out  output  1  one-cycle pulse on boundary crossing (wrap or saturate).
- cmp_eq  output  1  combinational (q == cmp).
- cmp_hit  output  1  one-cycle pulse: a count or load made q equal cmp.
- err  output  1  sticky: an illegal step was seen.

Behaviour:
- Reset (srst=0 at clk edge): q=0, carry_out=0, cmp_hit=0, err=0. Reset overrides all other inputs. Reset asserted mid-count discards any pending carry or hit.
- Priority per edge: srst > sload > ena. sload acts regardless of ena and sel.
- Load: q <= d_load, stored unchecked even if d_load > top. carry_out=0. cmp_hit=1 if d_load==cmp.
- Hold (ena=0, sload=0): q holds, carry_out=0, cmp_hit=0.
- Count (ena=1, sload=0), with s = zero-extended step and M = top+1, computed at WIDTH+1 bits, no overflow:
  - step=0: q holds, no carry, no hit.
  - q > top (out of range): up loads 0, down loads top; carry_out=1.
  - Up, q+s ≤ top: q <= q+s.
  - Up, q+s > top: wrap gives q <= q+s-M; saturate gives q <= top. carry_out=1.
  - Down, q ≥ s: q <= q-s.
  - Down, q < s: wrap gives q <= q+M-s; saturate gives q <= 0. carry_out=1.
  - Illegal step s > top, boundary case only: result is forced to the boundary (top for up, 0 for down) regardless of mode. carry_out=1, err <= 1.
- Latency: carry_out and cmp_hit are asserted in the same cycle the new q is presented, i.e. one clock after the ena/sload edge sample. Both are single-cycle pulses and are not held.
- cmp_hit on count: set when new q == cmp and (new q != old q). A held q never retriggers.
- err: sticky; set by an illegal step, cleared by err_clr. If set and clear occur in the same cycle, set wins.
- top=0: q stays 0 for any legal step=0. Any step ≥ 1 is illegal, so err=1 and carry_out=1 on every enabled count.
- Changing top or cmp mid-count takes effect on the next edge. No internal copy is held.

Optional Feature:
- Macro COUNTER_MOD_CAPTURE_EN.
- When defined, adds ports cap_strobe (input 1) and cap_q (output WIDTH, reset 0). When cap_strobe=1, cap_q <= the q value present before that edge's update.
- Adds cap_ovf (output 1, sticky, reset 0), set on a second strobe before cap_rd (input 1) acknowledges. cap_rd clears cap_ovf; on a simultaneous strobe and cap_rd, set wins.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- WIDTH=8, top=59, mode=0, sel=0, step=1, ena=1 from q=0 -> q counts 0..59 then 0; carry_out high exactly the cycle q shows 0; every 60 cycles.
- top=59, q=58, step=3, up, wrap -> q=1, carry_out=1. Same with mode=1 -> q=59, carry_out=1.
- top=59, q=2, step=5, down, wrap -> q=57, carry_out=1. Saturate -> q=0.
- top=10, q=9, step=12 (STEP_WIDTH=4), up -> q=10, err=1. err stays 1 until err_clr. err_clr and a new illegal step in the same cycle -> err stays 1.
- cmp=7, counting 5,6,7 with step=1 -> cmp_hit pulses once at q=7. Then ena=0 with q=7 -> cmp_eq=1, no further cmp_hit. sload d_load=7 -> cmp_hit pulse.
- Mid-count srst=0 with ena=1, sload=1 -> next edge q=0, carry_out=0, err=0. sload with d_load=200 while top=59 -> q=200; next up count -> q=0, carry_out=1.

Source files
------------

// File: rtl/counter_mod.sv
// Up/down modulo counter with programmable step, terminal value, compare and error flag.
// Optional capture register enabled by COUNTER_MOD_CAPTURE_EN.
module counter_mod #(
    parameter int WIDTH      = 8,
    parameter int STEP_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  ena,
    input  logic                  sel,
    input  logic                  mode,
    input  logic                  sload,
    input  logic [WIDTH-1:0]      d_load,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic [WIDTH-1:0]      top,
    input  logic [WIDTH-1:0]      cmp,
    input  logic                  err_clr,
    output logic [WIDTH-1:0]      q,
    output logic                  carry_out,
    output logic                  cmp_eq,
    output logic                  cmp_hit,
    output logic                  err
`ifdef COUNTER_MOD_CAPTURE_EN
    ,
    input  logic                  cap_strobe,
    input  logic                  cap_rd,
    output logic [WIDTH-1:0]      cap_q,
    output logic                  cap_ovf
`endif
);

    localparam int W1 = WIDTH + 1;

    // One extra bit so sums and the modulus never overflow.
    logic [W1-1:0]    qx;
    logic [W1-1:0]    tx;
    logic [W1-1:0]    sx;
    logic [W1-1:0]    mx;
    logic [W1-1:0]    sum;
    logic [WIDTH-1:0] up_add;
    logic [WIDTH-1:0] up_wrap;
    logic [WIDTH-1:0] dn_sub;
    logic [WIDTH-1:0] dn_wrap;

    assign qx      = {1'b0, q};
    assign tx      = {1'b0, top};
    assign sx      = W1'(step);
    assign mx      = tx + W1'(1);
    assign sum     = qx + sx;
    assign up_add  = WIDTH'(sum);
    assign up_wrap = WIDTH'(sum - mx);
    assign dn_sub  = WIDTH'(qx - sx);
    assign dn_wrap = WIDTH'(qx + mx - sx);

    logic             out_range;
    logic             illegal;
    logic             up_over;
    logic             dn_under;
    logic [WIDTH-1:0] cnt_q;
    logic             cnt_carry;
    logic             cnt_ill;

    assign out_range = (qx > tx);
    assign illegal   = (sx > tx);
    assign up_over   = (sum > tx);
    assign dn_under  = (qx < sx);

    // Result of an enabled count with a non-zero step.
    always_comb begin
        cnt_q     = q;
        cnt_carry = 1'b0;
        cnt_ill   = 1'b0;
        if (out_range) begin
            cnt_q     = sel ? top : '0;
            cnt_carry = 1'b1;
        end else if (illegal) begin
            cnt_q     = sel ? '0 : top;
            cnt_carry = 1'b1;
            cnt_ill   = 1'b1;
        end else if (!sel) begin
            if (!up_over) begin
                cnt_q = up_add;
            end else begin
                cnt_q     = mode ? top : up_wrap;
                cnt_carry = 1'b1;
            end
        end else begin
            if (!dn_under) begin
                cnt_q = dn_sub;
            end else begin
                cnt_q     = mode ? '0 : dn_wrap;
                cnt_carry = 1'b1;
            end
        end
    end

    logic [WIDTH-1:0] nxt_q;
    logic             nxt_carry;
    logic             nxt_hit;
    logic             set_err;

    always_comb begin
        nxt_q     = q;
        nxt_carry = 1'b0;
        nxt_hit   = 1'b0;
        set_err   = 1'b0;
        if (sload) begin
            nxt_q   = d_load;
            nxt_hit = (d_load == cmp);
        end else if (ena && (step != '0)) begin
            nxt_q     = cnt_q;
            nxt_carry = cnt_carry;
            set_err   = cnt_ill;
            nxt_hit   = (cnt_q == cmp) && (cnt_q != q);
        end
    end

    always_ff @(posedge clk) begin
        if (!srst) begin
            q         <= '0;
            carry_out <= 1'b0;
            cmp_hit   <= 1'b0;
            err       <= 1'b0;
        end else begin
            q         <= nxt_q;
            carry_out <= nxt_carry;
            cmp_hit   <= nxt_hit;
            if (set_err) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

    assign cmp_eq = (q == cmp);

`ifdef COUNTER_MOD_CAPTURE_EN
    // Pending marks a capture not yet acknowledged by cap_rd.
    logic cap_pend;

    always_ff @(posedge clk) begin
        if (!srst) begin
            cap_q    <= '0;
            cap_ovf  <= 1'b0;
            cap_pend <= 1'b0;
        end else begin
            if (cap_strobe) begin
                cap_q    <= q;
                cap_pend <= 1'b1;
            end else if (cap_rd) begin
                cap_pend <= 1'b0;
            end
            if (cap_strobe && cap_pend) begin
                cap_ovf <= 1'b1;
            end else if (cap_rd) begin
                cap_ovf <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_counter_mod.sv
// Self-checking bench for counter_mod: directed cases plus randomized
// stimulus against an arithmetic reference model.
module tb_counter_mod;

    localparam int WIDTH      = 8;
    localparam int STEP_WIDTH = 4;

    logic                  clk = 1'b0;
    logic                  srst;
    logic                  ena;
    logic                  sel;
    logic                  mode;
    logic                  sload;
    logic [WIDTH-1:0]      d_load;
    logic [STEP_WIDTH-1:0] step;
    logic [WIDTH-1:0]      top;
    logic [WIDTH-1:0]      cmp;
    logic                  err_clr;
    logic [WIDTH-1:0]      q;
    logic                  carry_out;
    logic                  cmp_eq;
    logic                  cmp_hit;
    logic                  err;
`ifdef COUNTER_MOD_CAPTURE_EN
    logic                  cap_strobe = 1'b0;
    logic                  cap_rd = 1'b0;
    logic [WIDTH-1:0]      cap_q;
    logic                  cap_ovf;
`endif

    counter_mod #(
        .WIDTH(WIDTH),
        .STEP_WIDTH(STEP_WIDTH)
    ) dut (
        .clk(clk),
        .srst(srst),
        .ena(ena),
        .sel(sel),
        .mode(mode),
        .sload(sload),
        .d_load(d_load),
        .step(step),
        .top(top),
        .cmp(cmp),
        .err_clr(err_clr),
        .q(q),
        .carry_out(carry_out),
        .cmp_eq(cmp_eq),
        .cmp_hit(cmp_hit),
        .err(err)
`ifdef COUNTER_MOD_CAPTURE_EN
        ,
        .cap_strobe(cap_strobe),
        .cap_rd(cap_rd),
        .cap_q(cap_q),
        .cap_ovf(cap_ovf)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int  mq;
    bit  mcarry;
    bit  mhit;
    bit  merr;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Next state from the rules, using plain integer arithmetic.
    task automatic model_step();
        int t, s, m, qq, nq;
        bit ill;
        t   = int'(top);
        s   = int'(step);
        m   = t + 1;
        qq  = mq;
        nq  = qq;
        ill = 1'b0;
        if (!srst) begin
            mq = 0; mcarry = 0; mhit = 0; merr = 0;
            return;
        end
        mcarry = 0;
        mhit   = 0;
        if (sload) begin
            nq   = int'(d_load);
            mhit = (nq == int'(cmp));
        end else if (ena && s != 0) begin
            if (qq > t) begin
                nq = sel ? t : 0;
                mcarry = 1;
            end else if (s > t) begin
                nq = sel ? 0 : t;
                mcarry = 1;
                ill = 1;
            end else if (!sel) begin
                if (qq + s <= t) nq = qq + s;
                else begin
                    mcarry = 1;
                    nq = mode ? t : (qq + s) % m;
                end
            end else begin
                if (qq >= s) nq = qq - s;
                else begin
                    mcarry = 1;
                    nq = mode ? 0 : (qq - s + m) % m;
                end
            end
            mhit = (nq == int'(cmp)) && (nq != qq);
        end
        if (ill) merr = 1;
        else if (err_clr) merr = 0;
        mq = nq;
    endtask

    task automatic compare_all();
        chk("q", int'(q), mq);
        chk("carry_out", int'(carry_out), int'(mcarry));
        chk("cmp_hit", int'(cmp_hit), int'(mhit));
        chk("err", int'(err), int'(merr));
        chk("cmp_eq", int'(cmp_eq), int'(mq == int'(cmp)));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic load(input int v);
        sload  = 1'b1;
        d_load = WIDTH'(v);
        tick();
        sload  = 1'b0;
    endtask

    int carries;

    initial begin
        srst = 1'b0; ena = 1'b0; sel = 1'b0; mode = 1'b0; sload = 1'b0;
        d_load = '0; step = '0; top = 8'd59; cmp = 8'd200; err_clr = 1'b0;
        mq = 0; mcarry = 0; mhit = 0; merr = 0;
        tick();
        chk("reset_q", int'(q), 0);
        chk("reset_carry", int'(carry_out), 0);
        chk("reset_err", int'(err), 0);
        srst = 1'b1;

        // Modulo-60 up count
        ena = 1'b1; step = 4'd1;
        carries = 0;
        for (int i = 1; i <= 120; i++) begin
            tick();
            if (carry_out) carries++;
            if (i == 59) chk("mod60_q59", int'(q), 59);
            if (i == 60) begin
                chk("mod60_wrap_q", int'(q), 0);
                chk("mod60_wrap_carry", int'(carry_out), 1);
            end
        end
        chk("mod60_carry_count", carries, 2);

        // Up boundary, wrap then saturate
        load(58); step = 4'd3; tick();
        chk("up_wrap_q", int'(q), 1);
        chk("up_wrap_carry", int'(carry_out), 1);
        mode = 1'b1; load(58); tick();
        chk("up_sat_q", int'(q), 59);
        chk("up_sat_carry", int'(carry_out), 1);

        // Down boundary, wrap then saturate
        sel = 1'b1; mode = 1'b0; step = 4'd5; load(2); tick();
        chk("dn_wrap_q", int'(q), 57);
        chk("dn_wrap_carry", int'(carry_out), 1);
        mode = 1'b1; load(2); tick();
        chk("dn_sat_q", int'(q), 0);

        // Illegal step
        sel = 1'b0; mode = 1'b0; top = 8'd10; load(9); step = 4'd12; tick();
        chk("ill_q", int'(q), 10);
        chk("ill_err", int'(err), 1);
        ena = 1'b0; tick(); tick();
        chk("err_sticky", int'(err), 1);
        ena = 1'b1; err_clr = 1'b1; tick();
        chk("err_set_wins", int'(err), 1);
        ena = 1'b0; tick();
        chk("err_cleared", int'(err), 0);
        err_clr = 1'b0;

        // Compare hit
        top = 8'd59; cmp = 8'd7; step = 4'd1; load(5);
        ena = 1'b1; tick();
        chk("hit_q6", int'(cmp_hit), 0);
        tick();
        chk("hit_q7", int'(cmp_hit), 1);
        ena = 1'b0; tick();
        chk("hit_hold", int'(cmp_hit), 0);
        chk("hold_eq", int'(cmp_eq), 1);
        load(7);
        chk("hit_load", int'(cmp_hit), 1);

        // Reset beats load/count
        top = 8'd10; step = 4'd12; ena = 1'b1; tick();
        srst = 1'b0; sload = 1'b1; d_load = 8'd33; tick();
        chk("rst_q", int'(q), 0);
        chk("rst_carry", int'(carry_out), 0);
        chk("rst_err", int'(err), 0);
        srst = 1'b1; sload = 1'b0;

        // Out-of-range load then count
        top = 8'd59; step = 4'd1; load(200);
        chk("oor_load", int'(q), 200);
        tick();
        chk("oor_q", int'(q), 0);
        chk("oor_carry", int'(carry_out), 1);

        // Randomized run
        for (int i = 0; i < 4000; i++) begin
            srst    = ($urandom_range(0, 99) != 0);
            sload   = ($urandom_range(0, 99) < 8);
            ena     = ($urandom_range(0, 99) < 85);
            sel     = 1'($urandom);
            mode    = 1'($urandom);
            err_clr = ($urandom_range(0, 99) < 6);
            step    = STEP_WIDTH'($urandom);
            d_load  = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom)
                                                  : WIDTH'($urandom_range(0, int'(top)));
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 3))
                    0: top = 8'd0;
                    1: top = 8'd10;
                    2: top = 8'd59;
                    default: top = WIDTH'($urandom);
                endcase
            end
            if ($urandom_range(0, 9) == 0)
                cmp = WIDTH'($urandom_range(0, int'(top)));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
